// File: rtl/gate_seq.sv
// gate_seq: operand sequencer for one LSTM gate. Streams x*w / h*u operand pairs and bias
// into the gate MACs, then captures the activation. Define GATE_SEQ_ABORT_EN for abort/aborted.
module gate_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int NUM_X = 8,
  parameter int NUM_H = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef GATE_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    x_addr,
  input  logic [WIDTH-1:0] x_data,
  output logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic [AW-1:0]    h_addr,
  input  logic [WIDTH-1:0] h_data,
  output logic [AW-1:0]    u_addr,
  input  logic [WIDTH-1:0] u_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             acc_x,
  output logic             acc_h,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_w,
  output logic [WIDTH-1:0] o_h,
  output logic [WIDTH-1:0] o_u,
  output logic [WIDTH-1:0] o_b,
  input  logic [WIDTH-1:0] i_gate,
  output logic [WIDTH-1:0] result
);

  localparam int            N      = (NUM_X > NUM_H) ? NUM_X : NUM_H;
  localparam int            CW     = $clog2(N + 1);
  localparam logic [CW-1:0] J_LAST = CW'(N - 1);
  localparam logic [CW-1:0] X_LEN  = CW'(NUM_X);
  localparam logic [CW-1:0] H_LEN  = CW'(NUM_H);
  localparam logic [AW-1:0] X_LAST = AW'(NUM_X - 1);
  localparam logic [AW-1:0] H_LAST = AW'(NUM_H - 1);

  if (FRAC < 0 || FRAC >= WIDTH || NUM_X < 1 || NUM_H < 1 || (2 ** AW) < N) begin : g_bad_cfg
    $error("gate_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_DRAIN, S_CAPT} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_j;
  logic             r_busy, r_done, r_acc_x, r_acc_h;
  logic [AW-1:0]    r_xw_addr, r_hu_addr;
  logic [WIDTH-1:0] r_o_x, r_o_w, r_o_h, r_o_u, r_o_b, r_result;
  logic             w_abort;

`ifdef GATE_SEQ_ABORT_EN
  logic r_aborted;
  assign w_abort = abort & r_busy;
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // Address counters saturate at the vector's last index instead of wrapping.
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a, input logic [AW-1:0] last);
    return (a == last) ? a : a + AW'(1);
  endfunction

  // NOTE: all state updates use non-blocking <= so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low; it is just another condition inside the clocked block.
    if (!rst) begin
      r_state   <= S_IDLE;
      r_j       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_acc_x   <= 1'b0;
      r_acc_h   <= 1'b0;
      r_xw_addr <= '0;
      r_hu_addr <= '0;
      r_o_x     <= '0;
      r_o_w     <= '0;
      r_o_h     <= '0;
      r_o_u     <= '0;
      r_o_b     <= '0;
      r_result  <= '0;
`ifdef GATE_SEQ_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_o_b  <= b_data;
      r_done <= 1'b0;
`ifdef GATE_SEQ_ABORT_EN
      r_aborted <= w_abort;
`endif
      if (w_abort) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_acc_x   <= 1'b0;
        r_acc_h   <= 1'b0;
        r_o_x     <= '0;
        r_o_w     <= '0;
        r_o_h     <= '0;
        r_o_u     <= '0;
        r_xw_addr <= '0;
        r_hu_addr <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state   <= S_FETCH;
              r_busy    <= 1'b1;
              r_xw_addr <= '0;
              r_hu_addr <= '0;
            end
          end
          S_FETCH: begin
            r_j       <= '0;
            r_xw_addr <= adv(r_xw_addr, X_LAST);
            r_hu_addr <= adv(r_hu_addr, H_LAST);
            r_state   <= S_RUN;
          end
          S_RUN: begin
            // Past a vector's end, feed zeros with accumulate held so that MAC sum stays put.
            if (r_j < X_LEN) begin
              r_o_x   <= x_data;
              r_o_w   <= w_data;
              r_acc_x <= (r_j != '0);
            end else begin
              r_o_x   <= '0;
              r_o_w   <= '0;
              r_acc_x <= 1'b1;
            end
            if (r_j < H_LEN) begin
              r_o_h   <= h_data;
              r_o_u   <= u_data;
              r_acc_h <= (r_j != '0);
            end else begin
              r_o_h   <= '0;
              r_o_u   <= '0;
              r_acc_h <= 1'b1;
            end
            r_xw_addr <= adv(r_xw_addr, X_LAST);
            r_hu_addr <= adv(r_hu_addr, H_LAST);
            if (r_j == J_LAST) r_state <= S_DRAIN;
            else               r_j     <= r_j + CW'(1);
          end
          S_DRAIN: begin
            r_o_x   <= '0;
            r_o_w   <= '0;
            r_o_h   <= '0;
            r_o_u   <= '0;
            r_acc_x <= 1'b1;
            r_acc_h <= 1'b1;
            r_state <= S_CAPT;
          end
          S_CAPT: begin
            r_result  <= i_gate;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_acc_x   <= 1'b0;
            r_acc_h   <= 1'b0;
            r_xw_addr <= '0;
            r_hu_addr <= '0;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign x_addr = r_xw_addr;
  assign w_addr = r_xw_addr;
  assign h_addr = r_hu_addr;
  assign u_addr = r_hu_addr;
  assign acc_x  = r_acc_x;
  assign acc_h  = r_acc_h;
  assign o_x    = r_o_x;
  assign o_w    = r_o_w;
  assign o_h    = r_o_h;
  assign o_u    = r_o_u;
  assign o_b    = r_o_b;
  assign result = r_result;

endmodule

// File: tb/tb_gate_seq.sv
// tb_gate_seq: three gate_seq instances (4/4, 3/5, 1/1 vector lengths) with memory and
// MAC/gate stubs; results compared against a dot-product reference model.
module tb_gate_seq;
  localparam int WIDTH = 32;
  localparam int FRAC  = 24;
  localparam int AW    = 8;
  localparam int NI    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start  [NI];
  logic             busy   [NI];
  logic             done   [NI];
  logic             acc_x  [NI];
  logic             acc_h  [NI];
  logic [AW-1:0]    x_addr [NI];
  logic [AW-1:0]    w_addr [NI];
  logic [AW-1:0]    h_addr [NI];
  logic [AW-1:0]    u_addr [NI];
  logic [WIDTH-1:0] o_x    [NI];
  logic [WIDTH-1:0] o_w    [NI];
  logic [WIDTH-1:0] o_h    [NI];
  logic [WIDTH-1:0] o_u    [NI];
  logic [WIDTH-1:0] o_b    [NI];
  logic [WIDTH-1:0] result [NI];
  logic [NI-1:0]    addr_bad;
`ifdef GATE_SEQ_ABORT_EN
  logic             abort   [NI];
  logic             aborted [NI];
`endif

  logic [WIDTH-1:0] mem_x [8];
  logic [WIDTH-1:0] mem_w [8];
  logic [WIDTH-1:0] mem_h [8];
  logic [WIDTH-1:0] mem_u [8];
  logic [WIDTH-1:0] b_data;
  logic [WIDTH-1:0] last_res [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int nx_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 3 : 1;
  endfunction

  function automatic int nh_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 5 : 1;
  endfunction

  // Signed fixed-point product as the downstream MAC computes it.
  function automatic logic [WIDTH-1:0] fx_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = $signed(a) * $signed(b);
    return p[FRAC +: WIDTH];
  endfunction

  // Expected gate output: bias plus both dot products (stub gate is linear).
  function automatic logic [WIDTH-1:0] ref_model(input int nx, input int nh);
    logic [WIDTH-1:0] s;
    s = b_data;
    for (int k = 0; k < nx; k++) s = s + fx_mul(mem_x[k], mem_w[k]);
    for (int k = 0; k < nh; k++) s = s + fx_mul(mem_h[k], mem_u[k]);
    return s;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int NX = (g == 0) ? 4 : (g == 1) ? 3 : 1;
    localparam int NH = (g == 0) ? 4 : (g == 1) ? 5 : 1;
    logic [WIDTH-1:0] x_data, w_data, h_data, u_data, i_gate, sum_x, sum_h;
    logic             bad;

    gate_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .NUM_X(NX), .NUM_H(NH), .AW(AW)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start[g]),
`ifdef GATE_SEQ_ABORT_EN
      .abort  (abort[g]),
      .aborted(aborted[g]),
`endif
      .busy   (busy[g]),
      .done   (done[g]),
      .x_addr (x_addr[g]),
      .x_data (x_data),
      .w_addr (w_addr[g]),
      .w_data (w_data),
      .h_addr (h_addr[g]),
      .h_data (h_data),
      .u_addr (u_addr[g]),
      .u_data (u_data),
      .b_data (b_data),
      .acc_x  (acc_x[g]),
      .acc_h  (acc_h[g]),
      .o_x    (o_x[g]),
      .o_w    (o_w[g]),
      .o_h    (o_h[g]),
      .o_u    (o_u[g]),
      .o_b    (o_b[g]),
      .i_gate (i_gate),
      .result (result[g])
    );

    initial bad = 1'b0;

    // Synchronous memories (1-cycle read latency) and the gate's two MAC registers.
    always @(posedge clk) begin
      x_data <= mem_x[x_addr[g][2:0]];
      w_data <= mem_w[w_addr[g][2:0]];
      h_data <= mem_h[h_addr[g][2:0]];
      u_data <= mem_u[u_addr[g][2:0]];
      if (x_addr[g] >= AW'(NX) || w_addr[g] != x_addr[g] ||
          h_addr[g] >= AW'(NH) || u_addr[g] != h_addr[g]) bad <= 1'b1;
      sum_x <= acc_x[g] ? sum_x + fx_mul(o_x[g], o_w[g]) : fx_mul(o_x[g], o_w[g]);
      sum_h <= acc_h[g] ? sum_h + fx_mul(o_h[g], o_u[g]) : fx_mul(o_h[g], o_u[g]);
    end

    assign i_gate      = sum_x + sum_h + o_b[g];
    assign addr_bad[g] = bad;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_const(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] w,
                           input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] u,
                           input logic [WIDTH-1:0] b);
    for (int k = 0; k < 8; k++) begin
      mem_x[k] = x; mem_w[k] = w; mem_h[k] = h; mem_u[k] = u;
    end
    b_data = b;
  endtask

  function automatic logic [WIDTH-1:0] rnd_fx();
    return WIDTH'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
  endfunction

  task automatic set_rand();
    for (int k = 0; k < 8; k++) begin
      mem_x[k] = rnd_fx(); mem_w[k] = rnd_fx(); mem_h[k] = rnd_fx(); mem_u[k] = rnd_fx();
    end
    b_data = rnd_fx();
  endtask

  // One evaluation on instance g: latency, busy span, result, one-cycle done.
  task automatic do_run(input int g, input string tag);
    int n, k, bcnt;
    logic [WIDTH-1:0] exp;
    n   = (nx_of(g) > nh_of(g)) ? nx_of(g) : nh_of(g);
    exp = ref_model(nx_of(g), nh_of(g));
    @(negedge clk); start[g] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[g] = 1'b0;
    k = 1; bcnt = 0;
    while (!done[g] && k < 60) begin
      bcnt += int'(busy[g]);
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, done[g], 1);
    check({tag, "_latency"}, k, n + 4);
    check({tag, "_busy_cycles"}, bcnt, n + 3);
    check({tag, "_busy_at_done"}, busy[g], 0);
    check({tag, "_result"}, result[g], exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, done[g], 0);
    last_res[g] = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd, d1, d2;
    logic [WIDTH-1:0] exp;
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
`ifdef GATE_SEQ_ABORT_EN
      abort[g] = 1'b0;
`endif
    end
    set_const('0, '0, '0, '0, 32'h0123_4567);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_busy", busy[g], 0);
      check("rst_done", done[g], 0);
      check("rst_acc", {acc_x[g], acc_h[g]}, 0);
      check("rst_addr", {x_addr[g], w_addr[g], h_addr[g], u_addr[g]}, 0);
      check("rst_operands", {o_x[g], o_h[g]}, 0);
      check("rst_o_b", o_b[g], 0);
      check("rst_result", result[g], 0);
    end
    rst = 1'b1;

    // Equal lengths: 4 x (1.0 * 0.25) = 1.0
    set_const(32'h0100_0000, 32'h0040_0000, '0, '0, '0);
    do_run(0, "t1");
    check("t1_value", result[0], 32'h0100_0000);

    // Unequal lengths 3/5: 3 + 5 - 2 = 6.0
    set_const(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'hFE00_0000);
    do_run(1, "t2");
    check("t2_value", result[1], 32'h0600_0000);

    for (int r = 0; r < 12; r++) begin
      set_rand();
      do_run(r % NI, "rand");
    end

    // Single-element vectors: 2.0*0.5 + 1.0*(-1.0) = 0.0
    set_const(32'h0200_0000, 32'h0080_0000, 32'h0100_0000, 32'hFF00_0000, '0);
    do_run(2, "t5");
    check("t5_value", result[2], 0);

    // start held high across done: exactly two runs, N+4 apart
    set_rand();
    exp = ref_model(4, 4);
    @(negedge clk); start[0] = 1'b1;
    nd = 0; d1 = -1; d2 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done[0]) begin
        nd++;
        check("t4_result", result[0], exp);
        if (d1 < 0) d1 = c; else d2 = c;
      end else if (d1 >= 0 && c == d1 + 1) begin
        start[0] = 1'b0;
      end
    end
    start[0] = 1'b0;
    check("t4_done_count", nd, 2);
    check("t4_spacing", d2 - d1, 8);
    last_res[0] = exp;

    // Reset during RUN j=2
    set_rand();
    @(negedge clk); start[1] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_busy_before", busy[1], 1);
    rst = 1'b0;
    @(negedge clk);
    check("t3_busy", busy[1], 0);
    check("t3_done", done[1], 0);
    check("t3_result", result[1], 0);
    check("t3_addr", {x_addr[1], h_addr[1]}, 0);
    check("t3_acc", {acc_x[1], acc_h[1]}, 0);
    rst = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done[1]) nd++;
    end
    check("t3_no_done", nd, 0);
    for (int g = 0; g < NI; g++) last_res[g] = '0;

`ifdef GATE_SEQ_ABORT_EN
    // Abort during RUN j=1 keeps the previous result
    set_rand();
    do_run(1, "t6_pre");
    set_rand();
    @(negedge clk); start[1] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[1] = 1'b0;
    repeat (2) @(negedge clk);
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    check("t6_aborted", aborted[1], 1);
    check("t6_busy", busy[1], 0);
    check("t6_done", done[1], 0);
    check("t6_acc", {acc_x[1], acc_h[1]}, 0);
    check("t6_operands", {o_x[1], o_w[1], o_h[1], o_u[1]}, 0);
    check("t6_result_kept", result[1], last_res[1]);
    @(negedge clk);
    check("t6_aborted_pulse", aborted[1], 0);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[1]) nd++;
    end
    check("t6_no_done", nd, 0);
    set_rand();
    do_run(1, "t6_post");
`endif

    for (int g = 0; g < NI; g++) check("addr_range", addr_bad[g], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
